// File: rtl/draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : draw_scheduler
// Description : Once per frame, snapshots the sprite object table (player,
//               enemies, bullets). It serialises draw requests for the active
//               objects to the rectangle drawer over a valid/ready handshake,
//               then evaluates rectangle-overlap collisions on the same
//               snapshot.
//   clk          : system clock
//   resetn       : synchronous reset, active-high despite the name
//   start        : begin a frame (sampled only while idle)
//   obj_*        : packed per-object fields, object i at [i*W +: W]
//   draw_ready   : drawer accepts the current request
//   draw_valid   : request valid; payload draw_x/y/w/h/colour and draw_idx
//   busy         : frame in progress
//   frame_done   : one-cycle pulse at the end of a frame
//   pe_collision : player vs enemy e
//   be_collision : bullet b vs enemy e at bit e*N_BULLET+b
// Revision    : 1.0 - initial release
// ============================================================================
module draw_scheduler #(
    parameter int  N_ENEMY  = 4,
    parameter int  N_BULLET = 1,
    parameter int  XW       = 8,
    parameter int  YW       = 7,
    parameter int  SW       = 5,
    parameter int  CW       = 3,
    localparam int N_OBJ    = 1 + N_ENEMY + N_BULLET,
    localparam int IW       = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [N_OBJ*XW-1:0]          obj_x,
    input  logic [N_OBJ*YW-1:0]          obj_y,
    input  logic [N_OBJ*SW-1:0]          obj_w,
    input  logic [N_OBJ*SW-1:0]          obj_h,
    input  logic [N_OBJ*CW-1:0]          obj_colour,
    input  logic [N_OBJ-1:0]             obj_active,
    input  logic                         draw_ready,
    output logic                         draw_valid,
    output logic [XW-1:0]                draw_x,
    output logic [YW-1:0]                draw_y,
    output logic [SW-1:0]                draw_w,
    output logic [SW-1:0]                draw_h,
    output logic [CW-1:0]                draw_colour,
    output logic [IW-1:0]                draw_idx,
    output logic                         busy,
    output logic                         frame_done,
    output logic [N_ENEMY-1:0]           pe_collision,
    output logic [N_ENEMY*N_BULLET-1:0]  be_collision
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_SCAN  = 3'd1;
    localparam logic [2:0] c_S_OFFER = 3'd2;
    localparam logic [2:0] c_S_CHECK = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    localparam logic [IW-1:0] c_LAST_IDX = IW'(N_OBJ - 1);

    logic [2:0]                    r_state;
    logic [IW-1:0]                 r_idx;

    logic [N_OBJ*XW-1:0]           r_snap_x;
    logic [N_OBJ*YW-1:0]           r_snap_y;
    logic [N_OBJ*SW-1:0]           r_snap_w;
    logic [N_OBJ*SW-1:0]           r_snap_h;
    logic [N_OBJ*CW-1:0]           r_snap_colour;
    logic [N_OBJ-1:0]              r_snap_active;

    logic                          r_draw_valid;
    logic [XW-1:0]                 r_draw_x;
    logic [YW-1:0]                 r_draw_y;
    logic [SW-1:0]                 r_draw_w;
    logic [SW-1:0]                 r_draw_h;
    logic [CW-1:0]                 r_draw_colour;
    logic [IW-1:0]                 r_draw_idx;
    logic                          r_frame_done;
    logic [N_ENEMY-1:0]            r_pe;
    logic [N_ENEMY*N_BULLET-1:0]   r_be;

    // Unpacked views of the snapshot so objects can be selected by index.
    logic [XW-1:0] w_x [N_OBJ];
    logic [YW-1:0] w_y [N_OBJ];
    logic [SW-1:0] w_w [N_OBJ];
    logic [SW-1:0] w_h [N_OBJ];
    logic [CW-1:0] w_c [N_OBJ];

    for (genvar i = 0; i < N_OBJ; i++) begin : g_unpack
        assign w_x[i] = r_snap_x[i*XW +: XW];
        assign w_y[i] = r_snap_y[i*YW +: YW];
        assign w_w[i] = r_snap_w[i*SW +: SW];
        assign w_h[i] = r_snap_h[i*SW +: SW];
        assign w_c[i] = r_snap_colour[i*CW +: CW];
    end

    // Strict inequalities make touching edges miss. Sums carry one extra bit
    // so objects near the right/bottom edge never wrap onto the left/top.
    // The explicit non-zero terms stop a degenerate rectangle from colliding.
    function automatic logic f_overlap(
        input logic          a_act,
        input logic          b_act,
        input logic [XW-1:0] ax,
        input logic [XW-1:0] bx,
        input logic [YW-1:0] ay,
        input logic [YW-1:0] by,
        input logic [SW-1:0] aw,
        input logic [SW-1:0] ah,
        input logic [SW-1:0] bw,
        input logic [SW-1:0] bh
    );
        logic [XW:0] w_ax_end;
        logic [XW:0] w_bx_end;
        logic [YW:0] w_ay_end;
        logic [YW:0] w_by_end;
        w_ax_end = (XW+1)'(ax) + (XW+1)'(aw);
        w_bx_end = (XW+1)'(bx) + (XW+1)'(bw);
        w_ay_end = (YW+1)'(ay) + (YW+1)'(ah);
        w_by_end = (YW+1)'(by) + (YW+1)'(bh);
        f_overlap = a_act && b_act &&
                    (aw != '0) && (ah != '0) && (bw != '0) && (bh != '0) &&
                    ((XW+1)'(ax) < w_bx_end) && ((XW+1)'(bx) < w_ax_end) &&
                    ((YW+1)'(ay) < w_by_end) && ((YW+1)'(by) < w_ay_end);
    endfunction

    logic [N_ENEMY-1:0]          w_pe;
    logic [N_ENEMY*N_BULLET-1:0] w_be;

    for (genvar e = 0; e < N_ENEMY; e++) begin : g_pe
        assign w_pe[e] = f_overlap(r_snap_active[0], r_snap_active[1+e],
                                   w_x[0], w_x[1+e], w_y[0], w_y[1+e],
                                   w_w[0], w_h[0], w_w[1+e], w_h[1+e]);
        for (genvar b = 0; b < N_BULLET; b++) begin : g_be
            localparam int c_B = 1 + N_ENEMY + b;
            assign w_be[e*N_BULLET+b] = f_overlap(
                r_snap_active[c_B], r_snap_active[1+e],
                w_x[c_B], w_x[1+e], w_y[c_B], w_y[1+e],
                w_w[c_B], w_h[c_B], w_w[1+e], w_h[1+e]);
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state       <= c_S_IDLE;
            r_idx         <= '0;
            r_snap_x      <= '0;
            r_snap_y      <= '0;
            r_snap_w      <= '0;
            r_snap_h      <= '0;
            r_snap_colour <= '0;
            r_snap_active <= '0;
            r_draw_valid  <= 1'b0;
            r_draw_x      <= '0;
            r_draw_y      <= '0;
            r_draw_w      <= '0;
            r_draw_h      <= '0;
            r_draw_colour <= '0;
            r_draw_idx    <= '0;
            r_frame_done  <= 1'b0;
            r_pe          <= '0;
            r_be          <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_snap_x      <= obj_x;
                        r_snap_y      <= obj_y;
                        r_snap_w      <= obj_w;
                        r_snap_h      <= obj_h;
                        r_snap_colour <= obj_colour;
                        r_snap_active <= obj_active;
                        r_idx         <= '0;
                        r_state       <= c_S_SCAN;
                    end
                end
                c_S_SCAN: begin
                    if (r_snap_active[r_idx]) begin
                        r_draw_x      <= w_x[r_idx];
                        r_draw_y      <= w_y[r_idx];
                        r_draw_w      <= w_w[r_idx];
                        r_draw_h      <= w_h[r_idx];
                        r_draw_colour <= w_c[r_idx];
                        r_draw_idx    <= r_idx;
                        r_draw_valid  <= 1'b1;
                        r_state       <= c_S_OFFER;
                    end else if (r_idx == c_LAST_IDX) begin
                        r_state <= c_S_CHECK;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_S_OFFER: begin
                    // Payload registers are untouched here, so they stay
                    // stable for the whole offer.
                    if (draw_ready) begin
                        r_draw_valid <= 1'b0;
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_S_CHECK;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= c_S_SCAN;
                        end
                    end
                end
                c_S_CHECK: begin
                    r_pe         <= w_pe;
                    r_be         <= w_be;
                    r_frame_done <= 1'b1;
                    r_state      <= c_S_DONE;
                end
                c_S_DONE: begin
                    r_frame_done <= 1'b0;
                    r_state      <= c_S_IDLE;
                end
                default: begin
                    r_draw_valid <= 1'b0;
                    r_frame_done <= 1'b0;
                    r_state      <= c_S_IDLE;
                end
            endcase
        end
    end

    assign draw_valid   = r_draw_valid;
    assign draw_x       = r_draw_x;
    assign draw_y       = r_draw_y;
    assign draw_w       = r_draw_w;
    assign draw_h       = r_draw_h;
    assign draw_colour  = r_draw_colour;
    assign draw_idx     = r_draw_idx;
    assign busy         = (r_state != c_S_IDLE);
    assign frame_done   = r_frame_done;
    assign pe_collision = r_pe;
    assign be_collision = r_be;

endmodule
`default_nettype wire

// File: tb/tb_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_scheduler
// Description : Self-checking bench for draw_scheduler. Stimulus computes the
//               expected draw sequence, collision vectors and frame length
//               from the object table and queues them. A negedge monitor
//               compares whatever the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_scheduler;

    localparam int N_ENEMY  = 4;
    localparam int N_BULLET = 1;
    localparam int XW       = 8;
    localparam int YW       = 7;
    localparam int SW       = 5;
    localparam int CW       = 3;
    localparam int N_OBJ    = 1 + N_ENEMY + N_BULLET;
    localparam int IW       = 3;

    logic                        clk = 1'b0;
    logic                        resetn;
    logic                        start;
    logic [N_OBJ*XW-1:0]         obj_x;
    logic [N_OBJ*YW-1:0]         obj_y;
    logic [N_OBJ*SW-1:0]         obj_w;
    logic [N_OBJ*SW-1:0]         obj_h;
    logic [N_OBJ*CW-1:0]         obj_colour;
    logic [N_OBJ-1:0]            obj_active;
    logic                        draw_ready;
    logic                        draw_valid;
    logic [XW-1:0]               draw_x;
    logic [YW-1:0]               draw_y;
    logic [SW-1:0]               draw_w;
    logic [SW-1:0]               draw_h;
    logic [CW-1:0]               draw_colour;
    logic [IW-1:0]               draw_idx;
    logic                        busy;
    logic                        frame_done;
    logic [N_ENEMY-1:0]          pe_collision;
    logic [N_ENEMY*N_BULLET-1:0] be_collision;

    draw_scheduler #(
        .N_ENEMY (N_ENEMY), .N_BULLET(N_BULLET),
        .XW(XW), .YW(YW), .SW(SW), .CW(CW)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
        .obj_colour(obj_colour), .obj_active(obj_active),
        .draw_ready(draw_ready), .draw_valid(draw_valid),
        .draw_x(draw_x), .draw_y(draw_y), .draw_w(draw_w), .draw_h(draw_h),
        .draw_colour(draw_colour), .draw_idx(draw_idx),
        .busy(busy), .frame_done(frame_done),
        .pe_collision(pe_collision), .be_collision(be_collision)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Object table as plain integers.
    int px[N_OBJ], py[N_OBJ], pw[N_OBJ], ph[N_OBJ], pc[N_OBJ], pact[N_OBJ];

    typedef struct {
        int idx, x, y, w, h, c;
    } req_t;
    req_t exp_q[$];

    int           exp_len;
    logic [3:0]   exp_pe;
    logic [3:0]   exp_be;
    int           dir_len = -1;
    int           dir_pe  = -1;
    int           dir_be  = -1;
    int           frames_seen = 0;
    int           ready_mode  = 0;
    int           stall_cnt   = 0;

    function automatic bit ovl(int a, int b);
        return (pact[a] != 0) && (pact[b] != 0) &&
               pw[a] > 0 && ph[a] > 0 && pw[b] > 0 && ph[b] > 0 &&
               px[a] < px[b] + pw[b] && px[b] < px[a] + pw[a] &&
               py[a] < py[b] + ph[b] && py[b] < py[a] + ph[a];
    endfunction

    task automatic model_and_pack();
        req_t r;
        for (int i = 0; i < N_OBJ; i++) begin
            obj_x[i*XW +: XW]      = XW'(px[i]);
            obj_y[i*YW +: YW]      = YW'(py[i]);
            obj_w[i*SW +: SW]      = SW'(pw[i]);
            obj_h[i*SW +: SW]      = SW'(ph[i]);
            obj_colour[i*CW +: CW] = CW'(pc[i]);
            obj_active[i]          = (pact[i] != 0);
        end
        exp_len = 2;
        for (int i = 0; i < N_OBJ; i++) begin
            if (pact[i] != 0) begin
                r = '{i, px[i], py[i], pw[i], ph[i], pc[i]};
                exp_q.push_back(r);
                exp_len += 2;
            end else begin
                exp_len += 1;
            end
        end
        for (int e = 0; e < N_ENEMY; e++) begin
            exp_pe[e] = ovl(0, 1 + e);
            for (int b = 0; b < N_BULLET; b++)
                exp_be[e*N_BULLET+b] = ovl(1 + N_ENEMY + b, 1 + e);
        end
    endtask

    task automatic scramble_ports();
        obj_x      = {$urandom, $urandom};
        obj_y      = {$urandom, $urandom};
        obj_w      = $urandom;
        obj_h      = $urandom;
        obj_colour = $urandom;
        obj_active = N_OBJ'($urandom);
    endtask

    // Runs one frame to completion; the monitor does the checking.
    task automatic run_frame(input int dlen, input int dpe, input int dbe);
        int f0;
        int t;
        dir_len = dlen; dir_pe = dpe; dir_be = dbe;
        model_and_pack();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_ports();  // snapshot must be immune to later input changes
        f0 = frames_seen;
        t  = 0;
        while (frames_seen == f0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
            if (t == 3) start = 1'b1;      // ignored while busy
            else        start = 1'b0;
        end
        start = 1'b0;
        if (frames_seen == f0) begin
            failures++;
            $display("FAIL frame_timeout: got no frame_done expected one within 3000 cycles");
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic set_obj(input int i, input int x, input int y, input int w,
                           input int h, input int a);
        px[i] = x; py[i] = y; pw[i] = w; ph[i] = h; pc[i] = i + 1; pact[i] = a;
    endtask

    // Drawer model: drives ready just after each edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: draw_ready = 1'b1;
            1: draw_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (draw_valid && draw_idx == 3'd2 && stall_cnt < 5) begin
                    draw_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    draw_ready = 1'b1;
                end
            end
            default: draw_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard.
    int   frame_cyc  = 0;
    int   stalls     = 0;
    bit   have_prev  = 0;
    bit   check_idle = 0;
    logic [63:0] prev_payload;
    req_t  er;

    always @(negedge clk) begin
        if (resetn) begin
            frame_cyc = 0; stalls = 0; have_prev = 0; check_idle = 0;
        end else begin
            if (check_idle) begin
                chk("busy_after_done", busy, 0);
                chk("frame_done_pulse", frame_done, 0);
                check_idle = 0;
            end
            if (busy) frame_cyc++;
            else begin frame_cyc = 0; stalls = 0; end
            if (have_prev && draw_valid)
                chk("payload_stable",
                    {draw_idx, draw_x, draw_y, draw_w, draw_h, draw_colour}, prev_payload);
            have_prev = 0;
            if (draw_valid && draw_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_draw", draw_idx, 7);
                end else begin
                    er = exp_q.pop_front();
                    chk("draw_idx", draw_idx, er.idx);
                    chk("draw_payload", {draw_x, draw_y, draw_w, draw_h, draw_colour},
                        {XW'(er.x), YW'(er.y), SW'(er.w), SW'(er.h), CW'(er.c)});
                end
            end else if (draw_valid) begin
                stalls++;
                have_prev    = 1;
                prev_payload = {draw_idx, draw_x, draw_y, draw_w, draw_h, draw_colour};
            end
            if (frame_done) begin
                chk("frame_len", frame_cyc, exp_len + stalls);
                if (dir_len >= 0) chk("frame_len_fixed", frame_cyc, dir_len);
                chk("pe_collision", pe_collision, exp_pe);
                chk("be_collision", be_collision, exp_be);
                if (dir_pe >= 0) chk("pe_fixed", pe_collision, dir_pe);
                if (dir_be >= 0) chk("be_fixed", be_collision, dir_be);
                chk("draws_remaining", exp_q.size(), 0);
                frames_seen++;
                check_idle = 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset with random inputs, start held high.
        resetn = 1'b1; start = 1'b1; draw_ready = 1'b1;
        scramble_ports();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs",
            {draw_valid, draw_x, draw_y, draw_w, draw_h, draw_colour, draw_idx,
             busy, frame_done, pe_collision, be_collision}, 0);
        @(posedge clk); #1;
        resetn = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        // All six active, ready high: 14-cycle frame.
        for (int i = 0; i < N_OBJ; i++)
            set_obj(i, 40 * i, 10 * i, 3 + i, 2 + i, 1);
        ready_mode = 0;
        run_frame(14, -1, -1);

        // Backpressure on idx 2 for 5 cycles.
        ready_mode = 2; stall_cnt = 0;
        run_frame(19, -1, -1);
        ready_mode = 0;

        // Edge cases for player vs enemy.
        set_obj(0, 10, 100, 16, 8, 1);
        set_obj(1, 26, 100, 8, 8, 1);
        set_obj(2, 20, 95, 8, 8, 1);
        set_obj(3, 120, 10, 8, 8, 1);
        set_obj(4, 150, 10, 8, 8, 1);
        set_obj(5, 200, 60, 4, 4, 1);
        run_frame(14, 4'b0010, -1);
        pact[2] = 0;
        run_frame(13, 4'b0000, -1);

        // No wrap-around at the right edge.
        set_obj(0, 5, 10, 16, 8, 1);
        set_obj(1, 100, 100, 8, 8, 1);
        set_obj(2, 60, 100, 8, 8, 1);
        set_obj(3, 250, 10, 16, 8, 1);
        set_obj(4, 252, 48, 8, 8, 1);
        set_obj(5, 250, 50, 4, 4, 1);
        run_frame(14, 4'b0000, 4'b1000);

        // Sparse activity.
        for (int i = 0; i < N_OBJ; i++) pact[i] = (i == 0 || i == 2);
        run_frame(10, -1, -1);

        // Random frames with random backpressure.
        ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (f % 2 == 0) set_obj(i, $urandom_range(0, 40), $urandom_range(0, 30),
                                        $urandom_range(0, 31), $urandom_range(0, 31),
                                        $urandom_range(0, 3) != 0);
                else            set_obj(i, $urandom_range(0, 255), $urandom_range(0, 127),
                                        $urandom_range(0, 31), $urandom_range(0, 31),
                                        $urandom_range(0, 1));
                pc[i] = $urandom_range(0, 7);
            end
            run_frame(-1, -1, -1);
        end

        // Reset in the middle of an offer.
        ready_mode = 3;
        for (int i = 0; i < N_OBJ; i++) set_obj(i, i, i, 4, 4, 1);
        model_and_pack();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!draw_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("offer_reached", draw_valid, 1);
        resetn = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_offer_valid", draw_valid, 0);
        chk("rst_mid_offer_busy", busy, 0);
        ready_mode = 0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
